// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FIFO defaults, the receive-timeout state encoding
// and the STAT register bit positions used by the register block.
package uart_pkg;

  localparam int          UART_RX_DEPTH_LOG2_DEF = 4;
  localparam logic [15:0] UART_RX_TMO_DEF        = 16'd4000;

  typedef enum logic [1:0] {
    TMO_IDLE    = 2'd0,
    TMO_COUNT   = 2'd1,
    TMO_EXPIRED = 2'd2
  } tmo_state_e;

  localparam int STAT_EMPTY_BIT   = 0;
  localparam int STAT_FULL_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;
  localparam int STAT_TMO_BIT     = 3;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// RX FIFO storage: one write port and one registered read port. The array is
// never reset; only the read register (the popped byte) has a reset value.
module uart_rx_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read of the slot being written in the same cycle returns the old byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller: pointers, occupancy, sticky overrun and level irq.
// Optional receive timeout compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH_LOG2     = UART_RX_DEPTH_LOG2_DEF,
  parameter logic [15:0] TIMEOUT_CYCLES = UART_RX_TMO_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          wdata,
  input  logic                wen,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  input  logic                flush,
  input  logic                clr_ovr,
  input  logic                irq_en,
  input  logic [DEPTH_LOG2:0] thresh,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overrun,
  output logic                irq
);

  localparam int                PTR_W = DEPTH_LOG2;
  localparam int                CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(2**DEPTH_LOG2);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push_acc, pop_acc, ovr_set, tmo_flag, irq_next;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_acc = !flush && wen && (!full || rd_en);
  assign pop_acc  = !flush && rd_en && !empty;
  assign ovr_set  = !flush && wen && full && !rd_en;

  always_comb begin
    count_next = count;
    if (flush)                     count_next = '0;
    else if (push_acc && !pop_acc) count_next = count + CNT_W'(1);
    else if (pop_acc && !push_acc) count_next = count - CNT_W'(1);
  end

  assign irq_next = irq_en && (((thresh != '0) && (count >= thresh)) || overrun || tmo_flag);

  uart_rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (8)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push_acc),
    .waddr   (wr_ptr),
    .wdata   (wdata),
    .re      (pop_acc),
    .raddr   (rd_ptr),
    .rdata   (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
      irq <= irq_next;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  tmo_state_e  tmo_state, tmo_state_nxt;
  logic [15:0] idle_cnt, idle_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_state <= TMO_IDLE;
      idle_cnt  <= '0;
    end else begin
      tmo_state <= tmo_state_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

  always_comb begin
    tmo_state_nxt = tmo_state;
    idle_cnt_nxt  = idle_cnt;
    if (flush) begin
      tmo_state_nxt = TMO_IDLE;
      idle_cnt_nxt  = '0;
    end else begin
      unique case (tmo_state)
        TMO_IDLE: begin
          idle_cnt_nxt = '0;
          if (count_next != '0) tmo_state_nxt = TMO_COUNT;
        end
        TMO_COUNT: begin
          if (count_next == '0) begin
            tmo_state_nxt = TMO_IDLE;
            idle_cnt_nxt  = '0;
          end else if (push_acc || pop_acc) begin
            idle_cnt_nxt = '0;
          end else if (idle_cnt == TIMEOUT_CYCLES - 16'd1) begin
            tmo_state_nxt = TMO_EXPIRED;
          end else begin
            idle_cnt_nxt = idle_cnt + 16'd1;
          end
        end
        TMO_EXPIRED: begin
          // Only a pop (or flush) acknowledges the timeout; pushes leave it set.
          if (pop_acc) begin
            tmo_state_nxt = (count_next == '0) ? TMO_IDLE : TMO_COUNT;
            idle_cnt_nxt  = '0;
          end
        end
        default: begin
          tmo_state_nxt = TMO_IDLE;
          idle_cnt_nxt  = '0;
        end
      endcase
    end
  end

  assign tmo_flag = (tmo_state == TMO_EXPIRED);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed scenarios plus random traffic, checked
// every cycle against a queue-based model. Honours `define UART_RX_TIMEOUT_EN.
module tb_uart_rx_fifo_ctrl;

  localparam int          DL2  = 4;
  localparam int          DEP  = 16;
  localparam logic [15:0] TMO  = 16'd10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   wdata;
  logic         wen, rd_en, flush, clr_ovr, irq_en;
  logic [DL2:0] thresh;
  logic [7:0]   rd_data;
  logic [DL2:0] count;
  logic         empty, full, overrun, irq;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] rd_m;
  bit         ovr_m, irq_m, tmo_m;
  int         idle_m;

  uart_rx_fifo_ctrl #(
    .DEPTH_LOG2     (DL2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wdata   (wdata),
    .wen     (wen),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .flush   (flush),
    .clr_ovr (clr_ovr),
    .irq_en  (irq_en),
    .thresh  (thresh),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .overrun (overrun),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rd_m   = 8'h00;
    ovr_m  = 1'b0;
    irq_m  = 1'b0;
    tmo_m  = 1'b0;
    idle_m = 0;
  endtask

  // Behaviour of one clock edge, derived from the FIFO rules directly.
  task automatic model_step();
    bit was_full, push, pop;
    irq_m = irq_en && (((thresh != 0) && (q.size() >= int'(thresh))) || ovr_m || tmo_m);
    if (flush) begin
      q.delete();
      idle_m = 0;
      tmo_m  = 1'b0;
      if (clr_ovr) ovr_m = 1'b0;
    end else begin
      was_full = (q.size() == DEP);
      pop  = rd_en && (q.size() > 0);
      push = wen && (!was_full || rd_en);
      if (pop)  rd_m = q.pop_front();
      if (push) q.push_back(wdata);
      if (wen && was_full && !rd_en) ovr_m = 1'b1;
      else if (clr_ovr)              ovr_m = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      if (q.size() == 0 || pop) begin
        idle_m = 0;
        tmo_m  = 1'b0;
      end else if (push) begin
        if (!tmo_m) idle_m = 0;
      end else if (!tmo_m) begin
        idle_m++;
        if (idle_m == int'(TMO)) tmo_m = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".count"},   32'(count),   32'(q.size()));
    chk({ctx, ".empty"},   32'(empty),   32'(q.size() == 0));
    chk({ctx, ".full"},    32'(full),    32'(q.size() == DEP));
    chk({ctx, ".overrun"}, 32'(overrun), 32'(ovr_m));
    chk({ctx, ".rd_data"}, 32'(rd_data), 32'(rd_m));
    chk({ctx, ".irq"},     32'(irq),     32'(irq_m));
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
    wen = w; wdata = d; rd_en = r; flush = f; clr_ovr = c;
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
    wen = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d); cyc(1, d, 0, 0, 0); endtask
  task automatic pop();                     cyc(0, 8'h00, 1, 0, 0); endtask
  task automatic idle();                    cyc(0, 8'h00, 0, 0, 0); endtask

  initial begin
    int phase, pw, pr;
    reset_n = 1'b0; wdata = 8'h00; wen = 1'b0; rd_en = 1'b0; flush = 1'b0;
    clr_ovr = 1'b0; irq_en = 1'b0; thresh = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Basic ordering and latency
    push(8'h41); push(8'h42); push(8'h43);
    chk("basic.count3", 32'(count), 32'd3);
    pop(); chk("basic.rd41", 32'(rd_data), 32'h41); chk("basic.count2", 32'(count), 32'd2);
    pop(); chk("basic.rd42", 32'(rd_data), 32'h42);
    pop(); chk("basic.rd43", 32'(rd_data), 32'h43); chk("basic.empty", 32'(empty), 32'd1);
    pop(); chk("basic.pop_empty_hold", 32'(rd_data), 32'h43);

    // Overrun on the 17th byte, drain, clear
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) chk("ovr.full16", 32'(full), 32'd1);
    end
    chk("ovr.set", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("ovr.drain", 32'(rd_data), 32'(i));
    end
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovr.clr", 32'(overrun), 32'd0);

    // Push+pop while full; push+pop while empty
    cyc(1, 8'h55, 1, 0, 0);
    chk("empty_pp.count", 32'(count), 32'd1);
    chk("empty_pp.no_bypass", 32'(rd_data), 32'h0F);
    pop();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    cyc(1, 8'hAA, 1, 0, 0);
    chk("full_pp.count", 32'(count), 32'd16);
    chk("full_pp.no_ovr", 32'(overrun), 32'd0);
    chk("full_pp.rd", 32'(rd_data), 32'h80);
    for (int i = 0; i < 16; i++) pop();
    chk("full_pp.last", 32'(rd_data), 32'hAA);

    // Threshold interrupt
    irq_en = 1'b1; thresh = 5'd4;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    chk("thr.irq_lag", 32'(irq), 32'd0);
    idle();
    chk("thr.irq_rise", 32'(irq), 32'd1);
    pop();
    chk("thr.irq_hold", 32'(irq), 32'd1);
    idle();
    chk("thr.irq_fall", 32'(irq), 32'd0);

    // Receive timeout
    cyc(0, 8'h00, 0, 1, 0);
    thresh = '0;
    push(8'h77);
    for (int i = 0; i < 10; i++) idle();
    chk("tmo.irq_lag", 32'(irq), 32'd0);
    idle();
`ifdef UART_RX_TIMEOUT_EN
    chk("tmo.irq_rise", 32'(irq), 32'd1);
    push(8'h78);
    idle();
    chk("tmo.push_keeps", 32'(irq), 32'd1);
    pop();
    idle();
    chk("tmo.pop_clears", 32'(irq), 32'd0);
`else
    chk("tmo.no_irq", 32'(irq), 32'd0);
`endif

    // Flush with a simultaneous push
    cyc(0, 8'h00, 0, 1, 0);
    irq_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    cyc(1, 8'hEE, 0, 1, 0);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(empty), 32'd1);
    chk("flush.ovr", 32'(overrun), 32'd0);
    chk("flush.rd_keep", 32'(rd_data), 32'h78 & {32{1'b0}} | 32'(rd_m));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        irq_en = 1'($urandom_range(0, 1));
        thresh = 5'($urandom_range(0, 16));
      end
      phase = (i / 250) % 4;
      case (phase)
        0:       begin pw = 70; pr = 20; end
        1:       begin pw = 20; pr = 70; end
        2:       begin pw = 2;  pr = 2;  end
        default: begin pw = 50; pr = 50; end
      endcase
      if (i == 2100) begin
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        @(negedge clk);
        reset_n = 1'b1;
      end
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
          $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
